// File: rtl/demux_1x4.sv
// Registered 1-to-4 demultiplexer: steers D to the Y output picked by {S1,S0}, one cycle of latency.
// Define DEMUX_1X4_HOLD_UNSEL_EN to keep non-selected outputs at their last value instead of clearing them.
module demux_1x4 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] D,
  input  logic             S0,
  input  logic             S1,
  output logic [WIDTH-1:0] Y0,
  output logic [WIDTH-1:0] Y1,
  output logic [WIDTH-1:0] Y2,
  output logic [WIDTH-1:0] Y3
);

  logic [1:0]       sel;
  logic [WIDTH-1:0] y_q [4];

  assign sel = {S1, S0};

  // One holding register per channel; each channel only decides its own next value.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_ch
      logic [WIDTH-1:0] y_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          y_reg <= '0;
        end else if (en) begin
          if (sel == 2'(gi)) begin
            y_reg <= D;
          end
`ifndef DEMUX_1X4_HOLD_UNSEL_EN
          else begin
            y_reg <= '0;
          end
`endif
        end
      end

      assign y_q[gi] = y_reg;
    end
  endgenerate

  assign Y0 = y_q[0];
  assign Y1 = y_q[1];
  assign Y2 = y_q[2];
  assign Y3 = y_q[3];

endmodule

// File: tb/tb_demux_1x4.sv
// Directed bench for demux_1x4: a WIDTH=1 and a WIDTH=8 instance share clock and reset.
// Expected values follow the build selected by DEMUX_1X4_HOLD_UNSEL_EN.
module tb_demux_1x4;

`ifdef DEMUX_1X4_HOLD_UNSEL_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic       clk;
  logic       rst_n;

  logic       en1;
  logic [0:0] d1;
  logic       s0_1, s1_1;
  logic [0:0] y0_1, y1_1, y2_1, y3_1;

  logic       en8;
  logic [7:0] d8;
  logic       s0_8, s1_8;
  logic [7:0] y0_8, y1_8, y2_8, y3_8;

  int errors = 0;
  int checks = 0;

  demux_1x4 #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en1), .D(d1), .S0(s0_1), .S1(s1_1),
    .Y0(y0_1), .Y1(y1_1), .Y2(y2_1), .Y3(y3_1)
  );

  demux_1x4 #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .en(en8), .D(d8), .S0(s0_8), .S1(s1_8),
    .Y0(y0_8), .Y1(y1_8), .Y2(y2_8), .Y3(y3_8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] out1();
    return {y3_1, y2_1, y1_1, y0_1};
  endfunction

  // Drive one WIDTH=1 transaction at the falling edge, return #1 after the rising edge.
  task automatic drive1(input logic e, input logic d, input logic [1:0] s);
    @(negedge clk);
    en1 = e; d1 = d; {s1_1, s0_1} = s;
    @(posedge clk);
    #1;
    $display("w1: en=%0b D=%0b sel=%0d -> Y3..Y0=%b", e, d, s, out1());
  endtask

  task automatic drive8(input logic e, input logic [7:0] d, input logic [1:0] s);
    @(negedge clk);
    en8 = e; d8 = d; {s1_8, s0_8} = s;
    @(posedge clk);
    #1;
    $display("w8: en=%0b D=%h sel=%0d -> Y3..Y0=%h_%h_%h_%h", e, d, s, y3_8, y2_8, y1_8, y0_8);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (out1() !== 4'b0000) begin errors++; $display("FAIL reset_w1: got %b want 0000", out1()); end
    checks++;
    if ({y3_8, y2_8, y1_8, y0_8} !== 32'h0) begin
      errors++; $display("FAIL reset_w8: got %h want 00000000", {y3_8, y2_8, y1_8, y0_8});
    end
    @(negedge clk); rst_n = 1'b1;
    drive1(1'b1, 1'b1, 2'd0);
    checks++;
    if (out1() !== 4'b0001) begin errors++; $display("FAIL load_y0: got %b want 0001", out1()); end
    // Assert reset mid-cycle and look before the next rising edge.
    #2; rst_n = 1'b0;
    #1;
    checks++;
    if (out1() !== 4'b0000) begin errors++; $display("FAIL async_clear: got %b want 0000", out1()); end
    drive1(1'b1, 1'b1, 2'd1);
    checks++;
    if (out1() !== 4'b0000) begin errors++; $display("FAIL reset_hold: got %b want 0000", out1()); end
    @(negedge clk); rst_n = 1'b1;
    drive1(1'b1, 1'b1, 2'd3);
    checks++;
    if (out1() !== 4'b1000) begin errors++; $display("FAIL first_after_release: got %b want 1000", out1()); end
  endtask

  task automatic test_sweep_ones();
    logic [3:0] exp_def [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [3:0] exp_hld [4] = '{4'b1001, 4'b1011, 4'b1111, 4'b1111};
    for (int i = 0; i < 4; i++) begin
      drive1(1'b1, 1'b1, 2'(i));
      checks++;
      if (out1() !== (HOLD ? exp_hld[i] : exp_def[i])) begin
        errors++;
        $display("FAIL sweep_ones sel=%0d: got %b want %b", i, out1(), HOLD ? exp_hld[i] : exp_def[i]);
      end
    end
  endtask

  task automatic test_sweep_zero();
    logic [3:0] exp_hld [4] = '{4'b1110, 4'b1100, 4'b1000, 4'b0000};
    for (int i = 0; i < 4; i++) begin
      drive1(1'b1, 1'b0, 2'(i));
      checks++;
      if (out1() !== (HOLD ? exp_hld[i] : 4'b0000)) begin
        errors++;
        $display("FAIL sweep_zero sel=%0d: got %b want %b", i, out1(), HOLD ? exp_hld[i] : 4'b0000);
      end
    end
  endtask

  task automatic test_enable_gating();
    drive1(1'b1, 1'b1, 2'd2);
    checks++;
    if (out1() !== 4'b0100) begin errors++; $display("FAIL gate_load: got %b want 0100", out1()); end
    for (int i = 0; i < 3; i++) begin
      drive1(1'b0, 1'b0, 2'd0);
      checks++;
      if (out1() !== 4'b0100) begin errors++; $display("FAIL gate_hold cyc=%0d: got %b want 0100", i, out1()); end
    end
    drive1(1'b1, 1'b0, 2'd0);
    checks++;
    if (out1() !== (HOLD ? 4'b0100 : 4'b0000)) begin
      errors++; $display("FAIL gate_release: got %b want %b", out1(), HOLD ? 4'b0100 : 4'b0000);
    end
  endtask

  task automatic test_width8();
    drive8(1'b1, 8'hA5, 2'd1);
    checks++;
    if ({y3_8, y2_8, y1_8, y0_8} !== 32'h0000A500) begin
      errors++; $display("FAIL w8_step1: got %h want 0000a500", {y3_8, y2_8, y1_8, y0_8});
    end
    drive8(1'b1, 8'h3C, 2'd3);
    checks++;
    if ({y3_8, y2_8, y1_8, y0_8} !== (HOLD ? 32'h3C00A500 : 32'h3C000000)) begin
      errors++;
      $display("FAIL w8_step2: got %h want %h", {y3_8, y2_8, y1_8, y0_8}, HOLD ? 32'h3C00A500 : 32'h3C000000);
    end
    drive8(1'b0, 8'hFF, 2'd0);
    checks++;
    if ({y3_8, y2_8, y1_8, y0_8} !== (HOLD ? 32'h3C00A500 : 32'h3C000000)) begin
      errors++; $display("FAIL w8_hold: got %h", {y3_8, y2_8, y1_8, y0_8});
    end
  endtask

  task automatic test_latency();
    logic       d_v   [3] = '{1'b1, 1'b0, 1'b1};
    logic [1:0] s_v   [3] = '{2'd1, 2'd2, 2'd3};
    logic [3:0] e_def [3] = '{4'b0010, 4'b0000, 4'b1000};
    logic [3:0] e_hld [3] = '{4'b0010, 4'b0010, 4'b1010};
    logic [3:0] prev;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    prev = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      en1 = 1'b1; d1 = d_v[i]; {s1_1, s0_1} = s_v[i];
      #4;
      checks++;
      if (out1() !== prev) begin errors++; $display("FAIL lat_pre step=%0d: got %b want %b", i, out1(), prev); end
      @(posedge clk);
      #1;
      prev = HOLD ? e_hld[i] : e_def[i];
      $display("w1: en=1 D=%0b sel=%0d -> Y3..Y0=%b", d_v[i], s_v[i], out1());
      checks++;
      if (out1() !== prev) begin errors++; $display("FAIL lat_post step=%0d: got %b want %b", i, out1(), prev); end
    end
  endtask

  initial begin
    en1 = 1'b0; d1 = '0; s0_1 = 1'b0; s1_1 = 1'b0;
    en8 = 1'b0; d8 = '0; s0_8 = 1'b0; s1_8 = 1'b0;
    test_reset();
    test_sweep_ones();
    test_sweep_zero();
    test_enable_gating();
    test_width8();
    test_latency();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
